// File: rtl/mem_responder_pkg.sv
// Shared encodings and widths for the mem_responder memory model.
// Used by mem_responder (top) and mem_latency_timer.
package mem_responder_pkg;

    localparam int MEM_WORD_W = 16;
    localparam int LAT_W      = 4;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

    // The counter is loaded with LATENCY-1 so that it reaches zero on the last BUSY edge
    function automatic logic [LAT_W-1:0] latency_load(input int latency);
        return LAT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_latency_timer.sv
// Load/decrement latency counter with a zero flag, used by mem_responder to time accesses.
module mem_latency_timer
    import mem_responder_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [LAT_W-1:0] count_q;
    logic [LAT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency, single-outstanding memory responder for the multi-cycle CPU bus.
// Optional request-consistency checker enabled by defining MEM_ERR_CHECK_EN (adds the mem_err port).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WORD_W  = MEM_WORD_W,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              readM,
    input  logic              writeM,
    input  logic [WORD_W-1:0] address,
    inout  wire  [WORD_W-1:0] data,
    output logic              inputReady
`ifdef MEM_ERR_CHECK_EN
    ,
    output logic              mem_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] ram [DEPTH];

    mem_state_e        state_q, state_d;
    mem_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              input_ready_q, input_ready_d;

    logic              accept;
    logic              timer_load;
    logic              timer_dec;
    logic              timer_zero;
    logic              ram_we;

    // Upper address bits alias onto the RAM index and are intentionally dropped
    logic              unused_addr;
    assign unused_addr = ^address;

    assign accept = (state_q == MEM_IDLE) && (readM || writeM);

    mem_latency_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (latency_load(LATENCY)),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        input_ready_d = 1'b0;
        timer_load    = 1'b0;
        timer_dec     = 1'b0;
        ram_we        = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                if (accept) begin
                    addr_d     = address[ADDR_W-1:0];
                    op_d       = writeM ? OP_WRITE : OP_READ;
                    timer_load = 1'b1;
                    state_d    = MEM_BUSY;
                    if (writeM) begin
                        wdata_d = data;
                    end
                end
            end
            MEM_BUSY: begin
                if (timer_zero) begin
                    state_d       = MEM_DONE;
                    input_ready_d = 1'b1;
                    if (op_q == OP_WRITE) begin
                        ram_we = 1'b1;
                    end else begin
                        rdata_d = ram[addr_q];
                    end
                end else begin
                    timer_dec = 1'b1;
                end
            end
            MEM_DONE: begin
                state_d = MEM_IDLE;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= MEM_IDLE;
            op_q          <= OP_READ;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            input_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            input_ready_q <= input_ready_d;
        end
    end

    // RAM has no reset; a write pending when reset hits is dropped
    always_ff @(posedge clk) begin
        if (reset_n && ram_we) begin
            ram[addr_q] <= wdata_q;
        end
    end

    assign inputReady = input_ready_q;
    assign data = ((state_q == MEM_DONE) && (op_q == OP_READ)) ? rdata_q : {WORD_W{1'bz}};

`ifdef MEM_ERR_CHECK_EN
    logic              req_read_q, req_read_d;
    logic              req_write_q, req_write_d;
    logic [WORD_W-1:0] req_addr_q, req_addr_d;
    logic              mem_err_q, mem_err_d;

    always_comb begin
        req_read_d  = req_read_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        mem_err_d   = 1'b0;
        if (accept) begin
            req_read_d  = readM;
            req_write_d = writeM;
            req_addr_d  = address;
            mem_err_d   = readM && writeM;
        end else if (state_q == MEM_BUSY) begin
            mem_err_d = (readM != req_read_q) || (writeM != req_write_q) ||
                        (address != req_addr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_read_q  <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            req_read_q  <= req_read_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`endif

endmodule
